// File: rtl/norflash_responder.sv
// Behavioural device end of an 8-bit parallel NOR flash bus: byte array, JEDEC-style
// unlock command decoding, ready/busy timing and DQ7/DQ6 status polling.
module norflash_responder #(
    parameter int unsigned AW           = 8,
    parameter logic [7:0]  MFR_ID       = 8'h01,
    parameter logic [7:0]  DEV_ID       = 8'hA4,
    parameter int unsigned PROG_CYCLES  = 4,
    parameter int unsigned ERASE_CYCLES = 16
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic [AW-1:0] flash_addr,
    input  logic [7:0]    flash_dq_i,
    output logic [7:0]    flash_dq_o,
    output logic          flash_dq_oe,
    input  logic          flash_ce_n,
    input  logic          flash_oe_n,
    input  logic          flash_we_n,
    input  logic          flash_rst_n,
    output logic          flash_ry_by_n
);

    localparam int unsigned DEPTH   = 1 << AW;
    localparam int unsigned MAX_CYC = (PROG_CYCLES > ERASE_CYCLES) ? PROG_CYCLES : ERASE_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    localparam logic [AW-1:0] ADDR_55 = AW'(8'h55);
    localparam logic [AW-1:0] ADDR_AA = AW'(8'hAA);
    localparam logic [AW-1:0] ADDR_00 = AW'(0);
    localparam logic [AW-1:0] ADDR_01 = AW'(1);

    localparam logic [3:0] ST_READ       = 4'd0;
    localparam logic [3:0] ST_UNLK1      = 4'd1;
    localparam logic [3:0] ST_UNLK2      = 4'd2;
    localparam logic [3:0] ST_PROG_DATA  = 4'd3;
    localparam logic [3:0] ST_ERS1       = 4'd4;
    localparam logic [3:0] ST_ERS2       = 4'd5;
    localparam logic [3:0] ST_ERS3       = 4'd6;
    localparam logic [3:0] ST_AUTOSEL    = 4'd7;
    localparam logic [3:0] ST_BUSY_PROG  = 4'd8;
    localparam logic [3:0] ST_BUSY_ERASE = 4'd9;

    logic [AW-1:0] addr_d;
    logic [7:0]    dq_d;
    logic          ce_n_d;
    logic          oe_n_d;
    logic          we_n_d;

    logic [3:0]    state;
    logic [3:0]    state_nxt;
    logic          load_prog;
    logic          load_erase;
    logic          prog_done;
    logic          erase_done;

    logic [CW-1:0] cnt;
    logic [AW-1:0] prog_addr;
    logic [7:0]    prog_data;
    logic [7:0]    mem [DEPTH];

    logic          dq6_tgl;
    logic          dq6_shown;
    logic          wr_ev;
    logic          read_start;
    logic          term;
    logic          busy_nxt;
    logic          rd_en;
    logic [7:0]    rd_data;

    // Bus input stage; addr_d/dq_d still hold the we_n-low values when the write event fires
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            addr_d <= '0;
            dq_d   <= 8'h00;
            ce_n_d <= 1'b1;
            oe_n_d <= 1'b1;
            we_n_d <= 1'b1;
        end else begin
            addr_d <= flash_addr;
            dq_d   <= flash_dq_i;
            ce_n_d <= flash_ce_n;
            oe_n_d <= flash_oe_n;
            we_n_d <= flash_we_n;
        end
    end

    assign wr_ev      = ~we_n_d & flash_we_n & ~ce_n_d & flash_rst_n;
    assign read_start = oe_n_d & ~flash_oe_n & ~flash_ce_n;
    assign term       = (cnt == CW'(1));
    assign busy_nxt   = (state_nxt == ST_BUSY_PROG) || (state_nxt == ST_BUSY_ERASE);
    assign rd_en      = ~ce_n_d & ~oe_n_d & we_n_d;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= ST_READ;
        else            state <= state_nxt;
    end

    // Command decoder
    always_comb begin
        state_nxt  = state;
        load_prog  = 1'b0;
        load_erase = 1'b0;
        prog_done  = 1'b0;
        erase_done = 1'b0;
        case (state)
            ST_READ: begin
                if (wr_ev)
                    state_nxt = (dq_d == 8'hAA && addr_d == ADDR_55) ? ST_UNLK1 : ST_READ;
            end
            ST_UNLK1: begin
                if (wr_ev)
                    state_nxt = (dq_d == 8'h55 && addr_d == ADDR_AA) ? ST_UNLK2 : ST_READ;
            end
            ST_UNLK2: begin
                if (wr_ev) begin
                    case (dq_d)
                        8'hA0:   state_nxt = ST_PROG_DATA;
                        8'h80:   state_nxt = ST_ERS1;
                        8'h90:   state_nxt = ST_AUTOSEL;
                        default: state_nxt = ST_READ;
                    endcase
                end
            end
            ST_PROG_DATA: begin
                if (wr_ev) begin
                    load_prog = 1'b1;
                    state_nxt = ST_BUSY_PROG;
                end
            end
            ST_ERS1: begin
                if (wr_ev)
                    state_nxt = (dq_d == 8'hAA && addr_d == ADDR_55) ? ST_ERS2 : ST_READ;
            end
            ST_ERS2: begin
                if (wr_ev)
                    state_nxt = (dq_d == 8'h55 && addr_d == ADDR_AA) ? ST_ERS3 : ST_READ;
            end
            ST_ERS3: begin
                if (wr_ev) begin
                    if (dq_d == 8'h10) begin
                        load_erase = 1'b1;
                        state_nxt  = ST_BUSY_ERASE;
                    end else begin
                        state_nxt  = ST_READ;
                    end
                end
            end
            ST_AUTOSEL: begin
                if (wr_ev && dq_d == 8'hF0) state_nxt = ST_READ;
            end
            ST_BUSY_PROG: begin
                if (term) begin
                    prog_done = 1'b1;
                    state_nxt = ST_READ;
                end
            end
            ST_BUSY_ERASE: begin
                if (term) begin
                    erase_done = 1'b1;
                    state_nxt  = ST_READ;
                end
            end
            default: state_nxt = ST_READ;
        endcase
        if (!flash_rst_n) begin
            state_nxt  = ST_READ;
            load_prog  = 1'b0;
            load_erase = 1'b0;
            prog_done  = 1'b0;
            erase_done = 1'b0;
        end
    end

    // Busy-time counter; terminal count is 1 so busy lasts exactly the loaded number of cycles
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= '0;
        end else if (!flash_rst_n) begin
            cnt <= '0;
        end else if (load_prog) begin
            cnt <= CW'(PROG_CYCLES);
        end else if (load_erase) begin
            cnt <= CW'(ERASE_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            prog_addr <= '0;
            prog_data <= 8'hFF;
        end else if (load_prog) begin
            prog_addr <= addr_d;
            prog_data <= dq_d;
        end
    end

    // Array: programming can only clear bits, erase sets every byte
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= 8'hFF;
        end else if (erase_done) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= 8'hFF;
        end else if (prog_done) begin
            mem[prog_addr] <= mem[prog_addr] & prog_data;
        end
    end

    // DQ6 shows the toggle state as it was when the current read started
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dq6_tgl   <= 1'b0;
            dq6_shown <= 1'b0;
        end else if (load_prog || load_erase) begin
            dq6_tgl   <= 1'b0;
            dq6_shown <= 1'b0;
        end else if (read_start) begin
            dq6_shown <= dq6_tgl;
            dq6_tgl   <= ~dq6_tgl;
        end
    end

    always_comb begin
        rd_data = mem[addr_d];
        case (state)
            ST_BUSY_PROG:  rd_data = {~prog_data[7], dq6_shown, 6'b000000};
            ST_BUSY_ERASE: rd_data = {1'b0, dq6_shown, 6'b000000};
            ST_AUTOSEL: begin
                if (addr_d == ADDR_00)      rd_data = MFR_ID;
                else if (addr_d == ADDR_01) rd_data = DEV_ID;
                else                        rd_data = 8'h00;
            end
            default: rd_data = mem[addr_d];
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            flash_dq_o    <= 8'h00;
            flash_dq_oe   <= 1'b0;
            flash_ry_by_n <= 1'b1;
        end else begin
            flash_dq_o    <= rd_en ? rd_data : 8'h00;
            flash_dq_oe   <= rd_en;
            flash_ry_by_n <= ~busy_nxt;
        end
    end

endmodule

// File: tb/tb_norflash_responder.sv
// Directed plus randomized bench for norflash_responder against a byte-array model
// of the flash command set.
module tb_norflash_responder;

    logic       clk;
    logic       rst_n;
    logic [7:0] addr;
    logic [7:0] dq_i;
    logic [7:0] dq_o;
    logic       dq_oe;
    logic       ce_n;
    logic       oe_n;
    logic       we_n;
    logic       frst_n;
    logic       ry;

    int checks;
    int failures;

    logic [7:0] model [256];
    logic [7:0] used_addr [8];

    norflash_responder #(
        .AW(8), .MFR_ID(8'h01), .DEV_ID(8'hA4), .PROG_CYCLES(4), .ERASE_CYCLES(16)
    ) dut (
        .sys_clk      (clk),
        .sys_rst_n    (rst_n),
        .flash_addr   (addr),
        .flash_dq_i   (dq_i),
        .flash_dq_o   (dq_o),
        .flash_dq_oe  (dq_oe),
        .flash_ce_n   (ce_n),
        .flash_oe_n   (oe_n),
        .flash_we_n   (we_n),
        .flash_rst_n  (frst_n),
        .flash_ry_by_n(ry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write cycle; returns on the negedge right after the write event has been committed
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk); addr = a; dq_i = d; ce_n = 1'b0; we_n = 1'b0;
        @(negedge clk); we_n = 1'b1;
        @(negedge clk); ce_n = 1'b1;
    endtask

    // Read cycle; data is sampled two cycles after oe_n falls
    task automatic rd(input logic [7:0] a, output logic [7:0] data, output logic oe, output logic oe_early);
        @(negedge clk); addr = a; ce_n = 1'b0; oe_n = 1'b0;
        @(negedge clk); oe_early = dq_oe;
        @(negedge clk); data = dq_o; oe = dq_oe;
        oe_n = 1'b1; ce_n = 1'b1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (ry === 1'b0 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic prog_cmd(input logic [7:0] a, input logic [7:0] d);
        wr(8'h55, 8'hAA); wr(8'hAA, 8'h55); wr(8'h55, 8'hA0); wr(a, d);
    endtask

    task automatic erase_cmd();
        wr(8'h55, 8'hAA); wr(8'hAA, 8'h55); wr(8'h55, 8'h80);
        wr(8'h55, 8'hAA); wr(8'hAA, 8'h55); wr(8'h55, 8'h10);
    endtask

    initial begin
        logic [7:0] data;
        logic       oe;
        logic       oe_early;
        int         n;
        logic [7:0] a;
        logic [7:0] d;

        checks   = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) model[i] = 8'hFF;
        rst_n = 1'b0; frst_n = 1'b1; ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
        addr = 8'h00; dq_i = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_dq_o", 32'(dq_o), 32'h00);
        chk("rst_dq_oe", 32'(dq_oe), 32'h0);
        chk("rst_ry", 32'(ry), 32'h1);
        rst_n = 1'b1;

        rd(8'h10, data, oe, oe_early);
        chk("read_erased", 32'(data), 32'(model[8'h10]));
        chk("read_oe", 32'(oe), 32'h1);
        chk("read_oe_early", 32'(oe_early), 32'h0);
        chk("idle_ry", 32'(ry), 32'h1);

        // First program: busy width, then data
        prog_cmd(8'h10, 8'h3C);
        wait_ready(n);
        chk("prog_busy_cycles", 32'(n), 32'd4);
        model[8'h10] = model[8'h10] & 8'h3C;
        rd(8'h10, data, oe, oe_early);
        chk("prog_read", 32'(data), 32'h3C);

        // Program over existing data clears bits only; status read during busy
        prog_cmd(8'h10, 8'hF0);
        rd(8'h10, data, oe, oe_early);
        chk("prog_status_f0", 32'(data), 32'h00);
        chk("prog_status_oe", 32'(oe), 32'h1);
        wait_ready(n);
        chk("prog_status_tail", 32'(n), 32'd1);
        model[8'h10] = model[8'h10] & 8'hF0;
        rd(8'h10, data, oe, oe_early);
        chk("and_rule", 32'(data), 32'h30);

        erase_cmd();
        wait_ready(n);
        chk("erase_busy_cycles", 32'(n), 32'd16);
        for (int i = 0; i < 256; i++) model[i] = 8'hFF;
        rd(8'h10, data, oe, oe_early);
        chk("erase_read", 32'(data), 32'hFF);

        // Autoselect
        wr(8'h55, 8'hAA); wr(8'hAA, 8'h55); wr(8'h55, 8'h90);
        rd(8'h00, data, oe, oe_early);
        chk("autosel_mfr", 32'(data), 32'h01);
        rd(8'h01, data, oe, oe_early);
        chk("autosel_dev", 32'(data), 32'hA4);
        rd(8'h02, data, oe, oe_early);
        chk("autosel_other", 32'(data), 32'h00);
        wr(8'h00, 8'hF0);
        rd(8'h00, data, oe, oe_early);
        chk("autosel_exit", 32'(data), 32'(model[8'h00]));

        // Randomized programs against the model
        for (int k = 0; k < 8; k++) begin
            a = 8'($urandom_range(0, 255));
            d = 8'($urandom);
            used_addr[k] = a;
            prog_cmd(a, d);
            rd(a, data, oe, oe_early);
            chk("rand_status", 32'(data), 32'({~d[7], 7'b0000000}));
            wait_ready(n);
            chk("rand_tail", 32'(n), 32'd1);
            model[a] = model[a] & d;
            rd(a, data, oe, oe_early);
            chk("rand_read", 32'(data), 32'(model[a]));
        end
        for (int k = 0; k < 4; k++) begin
            a = 8'($urandom_range(0, 255));
            rd(a, data, oe, oe_early);
            chk("rand_sweep", 32'(data), 32'(model[a]));
        end

        // Erase with DQ6 polling and an ignored F0 during busy
        erase_cmd();
        rd(8'h00, data, oe, oe_early);
        chk("erase_poll0", 32'(data), 32'h00);
        rd(8'h00, data, oe, oe_early);
        chk("erase_poll1", 32'(data), 32'h40);
        rd(8'h00, data, oe, oe_early);
        chk("erase_poll2", 32'(data), 32'h00);
        wr(8'h00, 8'hF0);
        wait_ready(n);
        chk("erase_f0_ignored", 32'(n), 32'd4);
        for (int i = 0; i < 256; i++) model[i] = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            rd(used_addr[k], data, oe, oe_early);
            chk("erase2_read", 32'(data), 32'(model[used_addr[k]]));
        end

        // Device reset pin aborts a program
        prog_cmd(8'h20, 8'h00);
        @(negedge clk); frst_n = 1'b0;
        @(negedge clk); frst_n = 1'b1;
        chk("rstpin_ry", 32'(ry), 32'h1);
        rd(8'h20, data, oe, oe_early);
        chk("rstpin_mem", 32'(data), 32'(model[8'h20]));

        // Broken unlock leaves the decoder idle
        wr(8'h55, 8'hAA); wr(8'hAA, 8'h12);
        wr(8'h55, 8'hA0); wr(8'h30, 8'h00);
        chk("broken_ry", 32'(ry), 32'h1);
        rd(8'h30, data, oe, oe_early);
        chk("broken_mem", 32'(data), 32'(model[8'h30]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
